// File: rtl/mdu_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// funct3 opcodes, FSM encoding and operand-sign helpers.
package mdu_pkg;

   localparam logic [2:0] MDU_MUL    = 3'b000;
   localparam logic [2:0] MDU_MULH   = 3'b001;
   localparam logic [2:0] MDU_MULHSU = 3'b010;
   localparam logic [2:0] MDU_MULHU  = 3'b011;
   localparam logic [2:0] MDU_DIV    = 3'b100;
   localparam logic [2:0] MDU_DIVU   = 3'b101;
   localparam logic [2:0] MDU_REM    = 3'b110;
   localparam logic [2:0] MDU_REMU   = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   function automatic logic is_div(input logic [2:0] f);
      return f[2];
   endfunction

   function automatic logic rs1_signed(input logic [2:0] f);
      return f inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
   endfunction

   function automatic logic rs2_signed(input logic [2:0] f);
      return f inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
   endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply (mode=0),
// restoring subtract for divide (mode=1).
module mdu_step #(
   parameter int XLEN = 32
) (
   input  logic            mode,
   input  logic [XLEN-1:0] acc,
   input  logic [XLEN-1:0] opr,
   input  logic [XLEN-1:0] opb,
   output logic [XLEN-1:0] acc_nxt,
   output logic [XLEN-1:0] opr_nxt
);

   logic [XLEN:0]   sum;
   logic [XLEN:0]   shl;
   logic [XLEN-1:0] dif;
   logic            ge;

   always_comb begin
      sum     = {1'b0, acc} + {1'b0, opb};
      shl     = {acc, opr[XLEN-1]};
      ge      = shl >= {1'b0, opb};
      // remainder after a successful subtract is below opb
      dif     = shl[XLEN-1:0] - opb;
      acc_nxt = acc;
      opr_nxt = opr;
      if (mode) begin
         acc_nxt = ge ? dif : shl[XLEN-1:0];
         opr_nxt = {opr[XLEN-2:0], ge};
      end else if (opr[0]) begin
         acc_nxt = sum[XLEN:1];
         opr_nxt = {sum[0], opr[XLEN-1:1]};
      end else begin
         acc_nxt = {1'b0, acc[XLEN-1:1]};
         opr_nxt = {acc[0], opr[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/ex_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit, one bit per cycle,
// with single-cycle bypass for zero/overflow special cases.
module ex_mdu
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] data_rs1,
   input  logic [XLEN-1:0] data_rs2,
   input  logic            flush,
   output logic            busy,
   output logic            valid_out,
   output logic [XLEN-1:0] data_out
);

   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t state, state_nxt;

   logic [CNT_W-1:0] cnt;
   logic [2:0]       f_q;
   logic             neg_a, neg_b;
   logic [XLEN-1:0]  acc, opr, opb;
   logic [XLEN-1:0]  acc_nxt, opr_nxt;
   logic [XLEN-1:0]  res_q, data_q;

   logic             accept, last, special;
   logic             sa, sb;
   logic [XLEN-1:0]  mag_a, mag_b;
   logic [XLEN-1:0]  spec_res, fix_res;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]  quo, rem;

   assign accept = (state == S_IDLE) && start && !flush;
   assign last   = (state == S_CALC) && (cnt == CNT_W'(1));

   always_comb begin
      sa    = rs1_signed(funct3) & data_rs1[XLEN-1];
      sb    = rs2_signed(funct3) & data_rs2[XLEN-1];
      mag_a = sa ? -data_rs1 : data_rs1;
      mag_b = sb ? -data_rs2 : data_rs2;
   end

   always_comb begin
      special  = 1'b0;
      spec_res = '0;
      if (is_div(funct3)) begin
         if (data_rs2 == '0) begin
            special  = 1'b1;
            spec_res = funct3[1] ? data_rs1 : '1;
         end else if (!funct3[0] && data_rs1 == MIN_NEG &&
                      data_rs2 == '1) begin
            special  = 1'b1;
            spec_res = funct3[1] ? '0 : MIN_NEG;
         end
      end else if (data_rs1 == '0 || data_rs2 == '0) begin
         special = 1'b1;
      end
   end

   mdu_step #(.XLEN(XLEN)) u_step (
      .mode    (is_div(f_q)),
      .acc     (acc),
      .opr     (opr),
      .opb     (opb),
      .acc_nxt (acc_nxt),
      .opr_nxt (opr_nxt)
   );

   // sign fix-up applied to the final iteration's output
   always_comb begin
      prod = {acc_nxt, opr_nxt};
      quo  = opr_nxt;
      rem  = acc_nxt;
      if (neg_a ^ neg_b) begin
         prod = -prod;
         quo  = -quo;
      end
      if (neg_a) rem = -rem;
      if (is_div(f_q))
         fix_res = f_q[1] ? rem : quo;
      else if (f_q[1:0] == 2'b00)
         fix_res = prod[XLEN-1:0];
      else
         fix_res = prod[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE: if (start) state_nxt = special ? S_DONE : S_CALC;
            S_CALC: if (last)  state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         f_q    <= '0;
         neg_a  <= 1'b0;
         neg_b  <= 1'b0;
         acc    <= '0;
         opr    <= '0;
         opb    <= '0;
         res_q  <= '0;
         data_q <= '0;
      end else begin
         if (accept) begin
            f_q   <= funct3;
            neg_a <= sa;
            neg_b <= sb;
            cnt   <= CNT_W'(XLEN);
            res_q <= spec_res;
            acc   <= '0;
            opr   <= is_div(funct3) ? mag_a : mag_b;
            opb   <= is_div(funct3) ? mag_b : mag_a;
         end else if (state == S_CALC) begin
            acc <= acc_nxt;
            opr <= opr_nxt;
            cnt <= cnt - 1'b1;
            if (last) res_q <= fix_res;
         end
         if (state == S_DONE && !flush) data_q <= res_q;
      end
   end

   assign busy      = (state != S_IDLE);
   assign valid_out = (state == S_DONE) && !flush;
   assign data_out  = valid_out ? res_q : data_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Randomised and directed bench for ex_mdu against a plain-arithmetic
// model of RV32M results and cycle latency.
module tb_ex_mdu;

   localparam int XLEN = 32;
   localparam logic [31:0] MINV = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  funct3 = '0;
   logic [31:0] data_rs1 = '0;
   logic [31:0] data_rs2 = '0;
   logic        flush = 1'b0;
   logic        busy;
   logic        valid_out;
   logic [31:0] data_out;

   int n_chk  = 0;
   int n_pass = 0;

   ex_mdu #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .funct3    (funct3),
      .data_rs1  (data_rs1),
      .data_rs2  (data_rs2),
      .flush     (flush),
      .busy      (busy),
      .valid_out (valid_out),
      .data_out  (data_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [31:0] ref_op(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      logic [63:0] sa, ua, sb, ub, p;
      logic signed [31:0] as, bs, r;
      logic ovf;
      sa  = {{32{a[31]}}, a};
      ua  = {32'b0, a};
      sb  = {{32{b[31]}}, b};
      ub  = {32'b0, b};
      as  = a;
      bs  = b;
      ovf = (a == MINV) && (b == '1);
      ref_op = '0;
      case (f)
         3'b000: begin p = sa * sb; ref_op = p[31:0];  end
         3'b001: begin p = sa * sb; ref_op = p[63:32]; end
         3'b010: begin p = sa * ub; ref_op = p[63:32]; end
         3'b011: begin p = ua * ub; ref_op = p[63:32]; end
         3'b100: begin
            if (b == '0) ref_op = '1;
            else if (ovf) ref_op = MINV;
            else begin r = as / bs; ref_op = r; end
         end
         3'b101: ref_op = (b == '0) ? '1 : a / b;
         3'b110: begin
            if (b == '0) ref_op = a;
            else if (ovf) ref_op = '0;
            else begin r = as % bs; ref_op = r; end
         end
         default: ref_op = (b == '0) ? a : a % b;
      endcase
   endfunction

   function automatic logic is_special(input logic [2:0] f,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
      if (f[2])
         return (b == '0) || (!f[0] && a == MINV && b == '1);
      return (a == '0) || (b == '0);
   endfunction

   // Model: in flight flag, cycles left to the result cycle, held output
   logic        m_busy = 1'b0;
   int          m_left = 0;
   logic [31:0] m_res  = '0;
   logic [31:0] m_data = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_left <= 0;
         m_res  <= '0;
         m_data <= '0;
      end else begin
         if (m_busy && m_left == 0 && !flush) m_data <= m_res;
         if (flush) begin
            m_busy <= 1'b0;
         end else if (m_busy) begin
            if (m_left == 0) m_busy <= 1'b0;
            else m_left <= m_left - 1;
         end else if (start) begin
            m_busy <= 1'b1;
            m_res  <= ref_op(funct3, data_rs1, data_rs2);
            m_left <= is_special(funct3, data_rs1, data_rs2) ? 0 : XLEN;
         end
      end
   end

   logic        e_valid;
   logic [31:0] e_data;

   always @(negedge clk) begin
      e_valid = m_busy && m_left == 0 && !flush;
      e_data  = e_valid ? m_res : m_data;
      check("busy", {63'b0, busy}, {63'b0, m_busy});
      check("valid_out", {63'b0, valid_out}, {63'b0, e_valid});
      check("data_out", {32'b0, data_out}, {32'b0, e_data});
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat, input string nm);
      int n;
      funct3   = f;
      data_rs1 = a;
      data_rs2 = b;
      start    = 1'b1;
      tick();
      start = 1'b0;
      n = 1;
      while (!valid_out && n < 40) begin
         tick();
         n++;
      end
      check({nm, " latency"}, 64'(n), 64'(lat));
      check({nm, " result"}, {32'b0, data_out}, {32'b0, exp});
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 7))
         0: return '0;
         1: return '1;
         2: return MINV;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int nv;
      logic [2:0] f;
      logic [31:0] a, b;
      #1 rst_n = 1'b0;
      repeat (3) tick();
      check("reset busy", {63'b0, busy}, 64'd0);
      check("reset valid", {63'b0, valid_out}, 64'd0);
      check("reset data", {32'b0, data_out}, 64'd0);
      rst_n = 1'b1;
      tick();

      check("pin mul", {32'b0, ref_op(3'b000, 7, -3)}, 64'hFFFF_FFEB);
      check("pin mulhsu", {32'b0, ref_op(3'b010, '1, 2)}, 64'hFFFF_FFFF);
      check("pin div", {32'b0, ref_op(3'b100, -7, 2)}, 64'hFFFF_FFFD);
      check("pin rem", {32'b0, ref_op(3'b110, -7, 2)}, 64'hFFFF_FFFF);
      check("pin divu0", {32'b0, ref_op(3'b101, 5, 0)}, 64'hFFFF_FFFF);
      check("pin removf", {32'b0, ref_op(3'b110, MINV, '1)}, 64'd0);

      do_op(3'b000, 7, -3, 32'hFFFF_FFEB, 33, "MUL");
      tick();
      do_op(3'b001, 7, -3, 32'hFFFF_FFFF, 33, "MULH");
      tick();
      do_op(3'b011, '1, '1, 32'hFFFF_FFFE, 33, "MULHU");
      tick();
      do_op(3'b100, -7, 2, 32'hFFFF_FFFD, 33, "DIV");
      tick();
      do_op(3'b110, -7, 2, 32'hFFFF_FFFF, 33, "REM");
      tick();
      do_op(3'b101, 100, 7, 14, 33, "DIVU");
      tick();
      do_op(3'b111, 100, 7, 2, 33, "REMU");
      tick();
      do_op(3'b101, 5, 0, 32'hFFFF_FFFF, 1, "DIVU by 0");
      tick();
      do_op(3'b110, 5, 0, 5, 1, "REM by 0");
      tick();
      do_op(3'b100, MINV, '1, MINV, 1, "DIV ovf");
      tick();
      do_op(3'b110, MINV, '1, 0, 1, "REM ovf");
      tick();
      do_op(3'b101, 100, 7, 14, 33, "DIVU pre-flush");
      tick();

      // flush mid-CALC
      funct3 = 3'b100; data_rs1 = 1000; data_rs2 = 3; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush busy drop", {63'b0, busy}, 64'd0);
      nv = 0;
      repeat (40) begin
         nv += int'(valid_out);
         tick();
      end
      check("flush no valid", 64'(nv), 64'd0);
      check("flush data hold", {32'b0, data_out}, 64'd14);
      do_op(3'b111, 100, 7, 2, 33, "REMU after flush");
      tick();

      // flush in the result cycle of a bypassed op
      funct3 = 3'b101; data_rs1 = 9; data_rs2 = 0; start = 1'b1;
      tick();
      start = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("done flush data", {32'b0, data_out}, 64'd2);
      check("done flush busy", {63'b0, busy}, 64'd0);

      // start+flush together in IDLE is dropped
      funct3 = 3'b000; data_rs1 = 3; data_rs2 = 4;
      start = 1'b1; flush = 1'b1;
      tick();
      start = 1'b0; flush = 1'b0;
      check("start+flush busy", {63'b0, busy}, 64'd0);
      tick();

      // start pulsed during CALC is ignored
      funct3 = 3'b101; data_rs1 = 1000; data_rs2 = 7; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      funct3 = 3'b000; data_rs1 = 55; data_rs2 = 5; start = 1'b1;
      tick();
      start = 1'b0;
      nv = 7;
      while (!valid_out && nv < 40) begin
         tick();
         nv++;
      end
      check("calc start latency", 64'(nv), 64'd33);
      check("calc start result", {32'b0, data_out}, 64'd142);

      // back-to-back: next start in the cycle after DONE
      tick();
      do_op(3'b000, 6, 7, 42, 33, "b2b first");
      tick();
      do_op(3'b010, -2, 3, 32'hFFFF_FFFF, 33, "b2b second");
      tick();

      // asynchronous reset mid-CALC
      funct3 = 3'b011; data_rs1 = 12345; data_rs2 = 678; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      #2 rst_n = 1'b0;
      #1;
      check("midreset busy", {63'b0, busy}, 64'd0);
      check("midreset valid", {63'b0, valid_out}, 64'd0);
      check("midreset data", {32'b0, data_out}, 64'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      nv = 0;
      repeat (40) begin
         nv += int'(valid_out);
         tick();
      end
      check("midreset no valid", 64'(nv), 64'd0);

      for (int i = 0; i < 200; i++) begin
         f = 3'($urandom_range(0, 7));
         a = rnd_val();
         b = rnd_val();
         do_op(f, a, b, ref_op(f, a, b),
               is_special(f, a, b) ? 1 : 33, "random");
         repeat ($urandom_range(1, 3)) tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Parametrised iterative multiply/divide unit for the RV32M (and RV64M-ready) extension.
- Sits in the execute stage beside the single-cycle integer ALU.
- Takes operands from data_rs1/data_rs2 and the instruction's funct3, iterates one bit per cycle, and returns the result with a valid pulse.
- The pipeline control holds the stage stalled while busy is high.

Parameters:
- XLEN, 32, operand/result width; must be even and >= 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; accepted only when busy=0.
- funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- data_rs1  input  XLEN  operand A (multiplicand / dividend).
- data_rs2  input  XLEN  operand B (multiplier / divisor).
- flush  input  1  abort in-flight op (branch/trap kill).
- busy  output  1  high from the cycle after acceptance until the result cycle, inclusive.
- valid_out  output  1  one-cycle result strobe.
- data_out  output  XLEN  result; held stable until the next accepted start.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state=IDLE, busy=0, valid_out=0, data_out=0, counter=0, internal accumulators=0.
- Reset mid-operation: the op is discarded immediately; no valid_out follows.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and flush=0: latch funct3, operand signs and absolute values.
  - Special case (see below): go to DONE.
  - Otherwise: counter=XLEN, go to CALC.
- CALC:
  - One radix-2 step per cycle; counter decrements.
  - When counter reaches 1, go to DONE after that step.
- DONE:
  - valid_out=1 for exactly this cycle; data_out is updated this cycle.
  - Next state IDLE.
- Latency, start accepted in cycle T:
  - Normal op: valid_out in cycle T+XLEN+1 (T+33 for XLEN=32).
  - Special case: valid_out in cycle T+1.
- start during CALC/DONE: ignored. No queueing; the producer must hold until busy=0.
- Back-to-back: start may be asserted in the cycle after DONE (IDLE). It is not accepted in the DONE cycle itself.
- flush:
  - Any state goes to IDLE next cycle; valid_out is suppressed and data_out is unchanged.
  - flush and start in the same IDLE cycle: flush wins, start is dropped.
- Multiply:
  - Shift-add on unsigned magnitudes into a 2*XLEN product.
  - Negate the product if the effective signs differ.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
  - MULHSU treats rs1 as signed and rs2 as unsigned.
- Divide:
  - Restoring division on magnitudes.
  - Quotient negated if the signs differ (DIV).
  - Remainder takes the dividend's sign (REM).
- Special cases (bypass CALC):
  - Divisor=0: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - Signed overflow (DIV/REM with rs1 = -2^(XLEN-1), rs2 = -1): DIV returns -2^(XLEN-1); REM returns 0.
  - Multiply with either operand=0: result 0.
- Width rules: all internal arithmetic is unsigned XLEN+1 bits for magnitudes. Negation is two's complement modulo 2^XLEN (or 2^(2*XLEN) for the product).

Decomposition:
- Package mdu_pkg holds:
  - funct3 localparams (MDU_MUL..MDU_REMU).
  - State encoding (IDLE/CALC/DONE).
  - Helpers is_div(funct3), rs1_signed(funct3), rs2_signed(funct3).
- One sub-module, mdu_step: a combinational single iteration.
  - Inputs: mode, accumulator, operand register.
  - Outputs: next accumulator and next operand.
  - Shared by the multiply and divide paths.
- ex_mdu owns the FSM, counter, sign fix-up, special-case detection and output register.

Test Plan:
- Reset: rst_n low mid-CALC -> busy=0, valid_out=0, data_out=0 immediately; no valid_out after release.
- MUL 7 x -3 (XLEN=32), start at T -> valid_out exactly at T+33 with data_out=0xFFFFFFEB. MULH same operands -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each with latency 33.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF at T+1.
  - REM 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0, at T+1.
- Flush at T+10 of a DIV -> busy drops at T+11, no valid_out, data_out keeps its prior value. Next start is accepted normally.
- start pulsed during CALC, and start+flush together in IDLE -> both ignored. Back-to-back start in the cycle after DONE -> accepted, second result correct.
